// File: rtl/checked_bootloader.sv
// Serial program loader: pulls a checksummed image from the SPART and writes it into
// instruction memory while holding the CPU in stall.
module checked_bootloader #(
  parameter logic [31:0] SPART_BASE = 32'h0000_001C,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned WORD_BYTES = 4,
  parameter logic [7:0]  BANNER     = 8'h42,
  parameter logic [7:0]  ACK_CHAR   = 8'h4B,
  parameter logic [7:0]  NAK_CHAR   = 8'h45
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    write_o,
  output logic                    read_o,
  output logic [31:0]             addr_o,
  output logic [31:0]             data_o,
  input  logic [31:0]             data_i,
  input  logic                    ack_i,
  input  logic                    reload_i,
  output logic [WORD_BYTES-1:0]   bl_strobe,
  output logic [8*WORD_BYTES-1:0] bl_data,
  output logic [ADDR_W-1:0]       bl_addr,
  output logic                    bl_stall,
  output logic                    boot_done,
  output logic                    boot_err
);

  localparam int unsigned WordW    = 8 * WORD_BYTES;
  localparam logic [1:0]  LastByte = 2'(WORD_BYTES - 1);
  localparam logic [32:0] Capacity = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {StBanner, StCount, StData, StCsum, StReply, StDone} state_e;

  state_e            state_q;
  logic [31:0]       n_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        sum_q;
  logic [WordW-1:0]  buf_q;
  logic              nak_q;
  logic              done_q;
  logic              err_q;

  logic [7:0]      rx_byte;
  logic [31:0]     n_full;
  logic            word_last;
  logic [ADDR_W:0] word_cnt_inc;
  logic            unused_data_hi;

  assign rx_byte        = data_i[7:0];
  assign unused_data_hi = ^data_i[31:8];
  assign n_full         = {rx_byte, n_q[31:8]};
  assign word_last      = (byte_cnt_q == LastByte);
  assign word_cnt_inc   = word_cnt_q + (ADDR_W + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBanner;
      n_q        <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      buf_q      <= '0;
      nak_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StBanner: begin
          if (ack_i) begin
            state_q    <= StCount;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            sum_q      <= '0;
          end
        end
        StCount: begin
          if (ack_i) begin
            n_q        <= n_full;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= '0;
              if ({1'b0, n_full} > Capacity) begin
                nak_q   <= 1'b1;
                state_q <= StReply;
              end else if (n_full == '0) begin
                state_q <= StCsum;
              end else begin
                state_q <= StData;
              end
            end
          end
        end
        StData: begin
          if (ack_i) begin
            sum_q <= sum_q + rx_byte;
            if (word_last) begin
              // N never exceeds 2**ADDR_W here, so its low ADDR_W+1 bits hold it exactly.
              byte_cnt_q <= '0;
              addr_q     <= addr_q + ADDR_W'(1);
              word_cnt_q <= word_cnt_inc;
              if (word_cnt_inc == n_q[ADDR_W:0]) begin
                state_q <= StCsum;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              for (int k = 0; k < int'(WORD_BYTES) - 1; k++) begin
                if (byte_cnt_q == 2'(k)) begin
                  buf_q[8*k +: 8] <= rx_byte;
                end
              end
            end
          end
        end
        StCsum: begin
          if (ack_i) begin
            nak_q   <= (rx_byte != sum_q);
            state_q <= StReply;
          end
        end
        StReply: begin
          if (ack_i) begin
            if (nak_q) begin
              err_q   <= 1'b1;
              state_q <= StBanner;
            end else begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (reload_i) begin
            done_q  <= 1'b0;
            state_q <= StBanner;
          end
        end
        default: state_q <= StBanner;
      endcase
    end
  end

  // Bus requests are a pure decode of the registered state, so they hold until the ack.
  always_comb begin
    write_o = 1'b0;
    read_o  = 1'b0;
    addr_o  = '0;
    data_o  = '0;
    unique case (state_q)
      StBanner: begin
        write_o = 1'b1;
        addr_o  = SPART_BASE;
        data_o  = {24'h0, BANNER};
      end
      StCount, StData, StCsum: begin
        read_o = 1'b1;
        addr_o = SPART_BASE + 32'd1;
      end
      StReply: begin
        write_o = 1'b1;
        addr_o  = SPART_BASE;
        data_o  = {24'h0, (nak_q ? NAK_CHAR : ACK_CHAR)};
      end
      default: ;
    endcase
  end

  always_comb begin
    bl_data                = buf_q;
    bl_data[WordW-1 -: 8]  = rx_byte;
  end

  assign bl_strobe = (state_q == StData && ack_i && word_last) ? '1 : '0;
  assign bl_addr   = addr_q;
  assign bl_stall  = (state_q != StDone);
  assign boot_done = done_q;
  assign boot_err  = err_q;

endmodule

// File: tb/tb_checked_bootloader.sv
// Scoreboard bench for checked_bootloader: a 4-byte/4-word instance and a 2-byte instance,
// each driven by a SPART bus model with random ack latency.
module tb_checked_bootloader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instance A: WORD_BYTES=4, ADDR_W=2 (4-word memory)
  logic        rst, reload;
  logic        wr_a, rd_a, ack_a, stall_a, done_a, err_a;
  logic [31:0] addr_a, wdat_a, rdat_a, bdat_a;
  logic [3:0]  strb_a;
  logic [1:0]  baddr_a;

  checked_bootloader #(.ADDR_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .write_o(wr_a), .read_o(rd_a), .addr_o(addr_a), .data_o(wdat_a),
    .data_i(rdat_a), .ack_i(ack_a), .reload_i(reload), .bl_strobe(strb_a), .bl_data(bdat_a),
    .bl_addr(baddr_a), .bl_stall(stall_a), .boot_done(done_a), .boot_err(err_a)
  );

  // Instance B: WORD_BYTES=2, default depth
  logic        rst_b, reload_b;
  logic        wr_b, rd_b, ack_b, stall_b, done_b, err_b;
  logic [31:0] addr_b, wdat_b, rdat_b;
  logic [15:0] bdat_b;
  logic [1:0]  strb_b;
  logic [13:0] baddr_b;

  checked_bootloader #(.WORD_BYTES(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .write_o(wr_b), .read_o(rd_b), .addr_o(addr_b), .data_o(wdat_b),
    .data_i(rdat_b), .ack_i(ack_b), .reload_i(reload_b), .bl_strobe(strb_b), .bl_data(bdat_b),
    .bl_addr(baddr_b), .bl_stall(stall_b), .boot_done(done_b), .boot_err(err_b)
  );

  logic [7:0]  rx_a[$], exp_tx_a[$], rx_b[$], exp_tx_b[$];
  wr_t         exp_wr_a[$], exp_wr_b[$];
  logic [31:0] word_q[$];
  bit          b_finished = 1'b0;

  // SPART model A: writes always complete, reads complete only when a byte is queued.
  initial begin
    int dly;
    wr_t e;
    dly    = 0;
    ack_a  = 1'b0;
    rdat_a = '0;
    forever begin
      @(negedge clk);
      ack_a  = 1'b0;
      rdat_a = '0;
      if (!rst && (wr_a || rd_a)) begin
        if (dly != 0) begin
          dly--;
        end else if (wr_a) begin
          ack_a = 1'b1;
          dly   = $urandom_range(0, 2);
          check("a_tx_addr", addr_a, 32'h1C);
          if (exp_tx_a.size() == 0) check("a_tx_extra", exp_tx_a.size(), 1);
          else check("a_tx_char", wdat_a, {24'h0, exp_tx_a.pop_front()});
        end else if (rx_a.size() != 0) begin
          ack_a  = 1'b1;
          dly    = $urandom_range(0, 2);
          rdat_a = {24'hA5A5A5, rx_a.pop_front()};
          check("a_rx_addr", addr_a, 32'h1D);
        end
      end
      #1;
      if (strb_a != '0) begin
        if (exp_wr_a.size() == 0) begin
          check("a_wr_extra", exp_wr_a.size(), 1);
        end else begin
          e = exp_wr_a.pop_front();
          check("a_wr_strobe", strb_a, 4'hF);
          check("a_wr_addr", baddr_a, e.addr);
          check("a_wr_data", bdat_a, e.data);
        end
      end
    end
  end

  // SPART model B
  initial begin
    wr_t e;
    ack_b  = 1'b0;
    rdat_b = '0;
    forever begin
      @(negedge clk);
      ack_b  = 1'b0;
      rdat_b = '0;
      if (!rst_b && wr_b) begin
        ack_b = 1'b1;
        if (exp_tx_b.size() == 0) check("b_tx_extra", exp_tx_b.size(), 1);
        else check("b_tx_char", wdat_b, {24'h0, exp_tx_b.pop_front()});
      end else if (!rst_b && rd_b && rx_b.size() != 0) begin
        ack_b  = 1'b1;
        rdat_b = {24'h5A5A5A, rx_b.pop_front()};
      end
      #1;
      if (strb_b != '0) begin
        if (exp_wr_b.size() == 0) begin
          check("b_wr_extra", exp_wr_b.size(), 1);
        end else begin
          e = exp_wr_b.pop_front();
          check("b_wr_strobe", strb_b, 2'b11);
          check("b_wr_addr", baddr_b, e.addr);
          check("b_wr_data", bdat_b, e.data);
        end
      end
    end
  end

  task automatic push_le32(input logic [31:0] v);
    for (int b = 0; b < 4; b++) rx_a.push_back(v[8*b +: 8]);
  endtask

  // Queues the image in word_q for instance A and the strobes it must produce.
  task automatic send_image_a(input logic [31:0] n, input bit bad);
    logic [7:0] sum;
    wr_t        e;
    sum = 8'h00;
    push_le32(n);
    for (int i = 0; i < word_q.size(); i++) begin
      for (int b = 0; b < 4; b++) begin
        rx_a.push_back(word_q[i][8*b +: 8]);
        sum = sum + word_q[i][8*b +: 8];
      end
      e.addr = i % 4;
      e.data = word_q[i];
      exp_wr_a.push_back(e);
    end
    rx_a.push_back(bad ? sum + 8'h01 : sum);
  endtask

  task automatic wait_done_a(input int budget);
    int c;
    c = 0;
    while (c < budget && !(done_a && !stall_a && rx_a.size() == 0 && exp_tx_a.size() == 0
                           && exp_wr_a.size() == 0)) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("a_done", done_a, 1'b1);
    check("a_stall_off", stall_a, 1'b0);
    check("a_rx_left", rx_a.size(), 0);
    check("a_tx_left", exp_tx_a.size(), 0);
    check("a_wr_left", exp_wr_a.size(), 0);
  endtask

  task automatic do_reload();
    exp_tx_a.push_back(8'h42);
    @(posedge clk);
    #1 reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    check("reload_stall", stall_a, 1'b1);
    check("reload_done", done_a, 1'b0);
    check("reload_wr", wr_a, 1'b1);
    check("reload_char", wdat_a, 32'h42);
  endtask

  task automatic check_idle_bus();
    check("idle_wr", wr_a, 1'b0);
    check("idle_rd", rd_a, 1'b0);
    check("idle_addr", addr_a, 32'h0);
    check("idle_data", wdat_a, 32'h0);
  endtask

  initial begin
    int c;
    rst    = 1'b1;
    reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall_a, 1'b1);
    check("rst_addr", baddr_a, 2'd0);
    check("rst_strobe", strb_a, 4'h0);
    check("rst_done", done_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_wr", wr_a, 1'b1);
    check("rst_rd", rd_a, 1'b0);
    check("rst_char", wdat_a, 32'h42);

    // Good two-word image
    exp_tx_a.push_back(8'h42);
    word_q = {32'h0000_0013, 32'h0010_0293};
    send_image_a(2, 1'b0);
    exp_tx_a.push_back(8'h4B);
    rst = 1'b0;
    wait_done_a(2000);
    check("t1_err", err_a, 1'b0);
    check("t1_addr", baddr_a, 2'd2);
    check_idle_bus();

    // Bad checksum, then automatic retry with a good image
    do_reload();
    send_image_a(2, 1'b1);
    exp_tx_a.push_back(8'h45);
    exp_tx_a.push_back(8'h42);
    send_image_a(2, 1'b0);
    exp_tx_a.push_back(8'h4B);
    c = 0;
    while (c < 2000 && exp_tx_a.size() > 2) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("t2_err_set", err_a, 1'b1);
    check("t2_done_low", done_a, 1'b0);
    wait_done_a(2000);
    check("t2_err_clr", err_a, 1'b0);

    // Oversize count is refused, then a full-depth image wraps bl_addr
    do_reload();
    push_le32(32'd5);
    exp_tx_a.push_back(8'h45);
    exp_tx_a.push_back(8'h42);
    word_q = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    send_image_a(4, 1'b0);
    exp_tx_a.push_back(8'h4B);
    wait_done_a(3000);
    check("t3_addr_wrap", baddr_a, 2'd0);
    check("t3_err", err_a, 1'b0);

    // Empty image
    do_reload();
    word_q = {};
    send_image_a(0, 1'b0);
    exp_tx_a.push_back(8'h4B);
    wait_done_a(1000);

    // Reset in the middle of the second word
    do_reload();
    push_le32(32'd2);
    push_le32(32'h0000_0013);
    exp_wr_a.push_back('{addr: 32'd0, data: 32'h0000_0013});
    rx_a.push_back(8'h93);
    rx_a.push_back(8'h02);
    rx_a.push_back(8'h10);
    c = 0;
    while (c < 1000 && rx_a.size() != 0) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t5_addr_mid", baddr_a, 2'd1);
    check("t5_wr_mid", exp_wr_a.size(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_addr", baddr_a, 2'd0);
    check("t5_rst_stall", stall_a, 1'b1);
    check("t5_rst_wr", wr_a, 1'b1);
    check("t5_rst_char", wdat_a, 32'h42);
    exp_tx_a.push_back(8'h42);
    word_q = {32'hDEAD_BEEF, 32'h0BAD_F00D};
    send_image_a(2, 1'b0);
    exp_tx_a.push_back(8'h4B);
    rst = 1'b0;
    wait_done_a(2000);
    check_idle_bus();

    c = 0;
    while (c < 2000 && !b_finished) begin
      @(posedge clk);
      c++;
    end
    check("b_finished", b_finished, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Instance B: single 16-bit word
  initial begin
    int c;
    rst_b    = 1'b1;
    reload_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_tx_b.push_back(8'h42);
    rx_b = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hFF};
    exp_wr_b.push_back('{addr: 32'd0, data: 32'h0000_55AA});
    exp_tx_b.push_back(8'h4B);
    rst_b = 1'b0;
    c = 0;
    while (c < 500 && !(done_b && rx_b.size() == 0 && exp_tx_b.size() == 0)) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("b_done", done_b, 1'b1);
    check("b_stall", stall_b, 1'b0);
    check("b_err", err_b, 1'b0);
    check("b_addr", baddr_b, 14'd1);
    check("b_wr_left", exp_wr_b.size(), 0);
    check("b_tx_left", exp_tx_b.size(), 0);
    b_finished = 1'b1;
  end

endmodule
